// File: rtl/svc_rv_imem_loader.sv
// Framed byte-stream IMEM loader: packs LE words, writes IMEM 1 cycle after a word's 4th byte.
// Holds cpu_rst until a good checksum; s_ready is high whenever out of reset (no backpressure).
`timescale 1ns/1ps
module svc_rv_imem_loader #(
  parameter int          IMEM_AW = 5,
  parameter logic [7:0]  MAGIC   = 8'hA5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  input  logic [7:0]         s_data,
  output logic               s_ready,
  output logic               imem_wen,
  output logic [IMEM_AW-1:0] imem_waddr,
  output logic [31:0]        imem_wdata,
  output logic               cpu_rst,
  output logic               load_done,
  output logic               load_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_LO,
    S_CNT_HI,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [16:0]      CAP      = 17'(1) << IMEM_AW;
  localparam logic [IMEM_AW:0] ONE_WORD = (IMEM_AW+1)'(1);

  state_t             state_q, state_d;
  logic [7:0]         cnt_lo_q, cnt_lo_d;
  logic [IMEM_AW:0]   words_left_q, words_left_d;
  logic [1:0]         byte_idx_q, byte_idx_d;
  logic [31:0]        word_q, word_d;
  logic [7:0]         sum_q, sum_d;
  logic               inc_pending_q, inc_pending_d;

  logic               imem_wen_d;
  logic [IMEM_AW-1:0] imem_waddr_d;
  logic [31:0]        imem_wdata_d;
  logic               cpu_rst_d, load_done_d, load_err_d;

  logic               accept;
  logic [7:0]         sum_next;
  logic [16:0]        n_full;
  logic [31:0]        word_next;

  assign accept    = s_valid && s_ready;
  assign sum_next  = sum_q + s_data;
  assign n_full    = {1'b0, s_data, cnt_lo_q};
  assign word_next = {s_data, word_q[31:8]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_lo_d      = cnt_lo_q;
    words_left_d  = words_left_q;
    byte_idx_d    = byte_idx_q;
    word_d        = word_q;
    sum_d         = sum_q;
    inc_pending_d = 1'b0;
    imem_wen_d    = 1'b0;
    imem_wdata_d  = imem_wdata;
    cpu_rst_d     = cpu_rst;
    load_done_d   = load_done;
    load_err_d    = load_err;
    // The address steps the cycle after a non-final write, so the strobe sees the old address.
    imem_waddr_d  = inc_pending_q ? imem_waddr + 1'b1 : imem_waddr;

    if (accept) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERR: begin
          if (s_data == MAGIC) begin
            state_d      = S_CNT_LO;
            cpu_rst_d    = 1'b1;
            load_done_d  = 1'b0;
            load_err_d   = 1'b0;
            imem_waddr_d = '0;
            sum_d        = '0;
            byte_idx_d   = '0;
          end
        end
        S_CNT_LO: begin
          cnt_lo_d = s_data;
          state_d  = S_CNT_HI;
        end
        S_CNT_HI: begin
          if (n_full > CAP) begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end else if (n_full == '0) begin
            state_d = S_CHK;
          end else begin
            state_d      = S_DATA;
            words_left_d = n_full[IMEM_AW:0];
          end
        end
        S_DATA: begin
          word_d     = word_next;
          sum_d      = sum_next;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            imem_wen_d   = 1'b1;
            imem_wdata_d = word_next;
            words_left_d = words_left_q - ONE_WORD;
            if (words_left_q == ONE_WORD) begin
              state_d = S_CHK;
            end else begin
              inc_pending_d = 1'b1;
            end
          end
        end
        S_CHK: begin
          if (sum_next == 8'd0) begin
            state_d     = S_DONE;
            cpu_rst_d   = 1'b0;
            load_done_d = 1'b1;
          end else begin
            state_d    = S_ERR;
            load_err_d = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lo_q      <= '0;
      words_left_q  <= '0;
      byte_idx_q    <= '0;
      word_q        <= '0;
      sum_q         <= '0;
      inc_pending_q <= 1'b0;
      s_ready       <= 1'b0;
      imem_wen      <= 1'b0;
      imem_waddr    <= '0;
      imem_wdata    <= '0;
      cpu_rst       <= 1'b1;
      load_done     <= 1'b0;
      load_err      <= 1'b0;
    end else begin
      cnt_lo_q      <= cnt_lo_d;
      words_left_q  <= words_left_d;
      byte_idx_q    <= byte_idx_d;
      word_q        <= word_d;
      sum_q         <= sum_d;
      inc_pending_q <= inc_pending_d;
      s_ready       <= 1'b1;
      imem_wen      <= imem_wen_d;
      imem_waddr    <= imem_waddr_d;
      imem_wdata    <= imem_wdata_d;
      cpu_rst       <= cpu_rst_d;
      load_done     <= load_done_d;
      load_err      <= load_err_d;
    end
  end

endmodule

// File: tb/tb_svc_rv_imem_loader.sv
// Directed bench for svc_rv_imem_loader: frame vector table plus multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_svc_rv_imem_loader;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic          imem_wen;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          cpu_rst;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  svc_rv_imem_loader #(.IMEM_AW(AW), .MAGIC(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_data     (s_data),
    .s_ready    (s_ready),
    .imem_wen   (imem_wen),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .load_done  (load_done),
    .load_err   (load_err)
  );

  logic [31:0] mem [32];
  int          wr_total = 0;

  always @(posedge clk) begin
    if (imem_wen) begin
      mem[imem_waddr] <= imem_wdata;
      wr_total        <= wr_total + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Presents one byte after gap idle cycles; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    t = 0;
    while (!s_ready && t < 50) begin @(posedge clk); #1; t++; end
    if (!s_ready) check("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  typedef struct {
    logic [0:15][7:0] b;
    int               len;
    logic             done;
    logic             err;
    logic             crst;
    int               nwr;
    logic [31:0]      w0;
    logic [31:0]      w1;
  } vec_t;

  function automatic vec_t mk(input logic [127:0] b, input int len, input logic d, input logic e,
                              input logic c, input int nwr, input logic [31:0] w0, input logic [31:0] w1);
    vec_t v;
    v.b = b; v.len = len; v.done = d; v.err = e; v.crst = c; v.nwr = nwr; v.w0 = w0; v.w1 = w1;
    return v;
  endfunction

  vec_t vecs [8];
  int   base;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Data sum 0x13+0x73+0x10 = 0x96, so 0x6A closes the checksum; 0x11 does not.
    vecs[0] = mk(128'hA5020013000000730010006A00000000, 12, 1, 0, 0, 2, 32'h00000013, 32'h00100073);
    vecs[1] = mk(128'hA5020013000000730010001100000000, 12, 0, 1, 1, 2, 32'h00000013, 32'h00100073);
    vecs[2] = mk(128'hA5210000000000000000000000000000,  3, 0, 1, 1, 0, 32'h0, 32'h0);
    vecs[3] = mk(128'hA5000000000000000000000000000000,  4, 1, 0, 0, 0, 32'h0, 32'h0);
    // MAGIC inside data is payload: sum 4*0xA5 = 0x94, CHK 0x6C.
    vecs[4] = mk(128'hA50100A5A5A5A56C0000000000000000,  8, 1, 0, 0, 1, 32'hA5A5A5A5, 32'h0);
    // MAGIC as CNT_LO gives N=165, too large.
    vecs[5] = mk(128'hA5A50000000000000000000000000000,  3, 0, 1, 1, 0, 32'h0, 32'h0);
    // Leading junk is dropped; sum 0x114 -> 0x14, CHK 0xEC.
    vecs[6] = mk(128'h55A5010078563412EC00000000000000,  9, 1, 0, 0, 1, 32'h12345678, 32'h0);
    vecs[7] = mk(128'hA5000001000000000000000000000000,  4, 0, 1, 1, 0, 32'h0, 32'h0);

    rst = 1'b1; s_valid = 1'b0; s_data = 8'h00;
    idle(3);
    check("rst_s_ready",    32'(s_ready),   32'd0);
    check("rst_imem_wen",   32'(imem_wen),  32'd0);
    check("rst_imem_waddr", 32'(imem_waddr), 32'd0);
    check("rst_imem_wdata", imem_wdata,     32'd0);
    check("rst_cpu_rst",    32'(cpu_rst),   32'd1);
    check("rst_load_done",  32'(load_done), 32'd0);
    check("rst_load_err",   32'(load_err),  32'd0);
    rst = 1'b0;
    idle(1);
    check("ready_after_rst", 32'(s_ready), 32'd1);

    for (int i = 0; i < 8; i++) begin
      base = wr_total;
      for (int k = 0; k < vecs[i].len; k++)
        send(vecs[i].b[k], (i % 2 == 1) ? int'($urandom_range(0, 3)) : 0);
      idle(2);
      $display("vector %0d", i);
      check("vec_load_done", 32'(load_done), 32'(vecs[i].done));
      check("vec_load_err",  32'(load_err),  32'(vecs[i].err));
      check("vec_cpu_rst",   32'(cpu_rst),   32'(vecs[i].crst));
      check("vec_nwrites",   32'(wr_total - base), 32'(vecs[i].nwr));
      if (vecs[i].nwr >= 1) check("vec_imem0", mem[0], vecs[i].w0);
      if (vecs[i].nwr >= 2) check("vec_imem1", mem[1], vecs[i].w1);
    end

    // Empty frame from ERR: cpu_rst drops on the 4th cycle after MAGIC.
    send(8'hA5, 0); check("t4_cpu_rst_c1", 32'(cpu_rst), 32'd1);
    send(8'h00, 0); check("t4_cpu_rst_c2", 32'(cpu_rst), 32'd1);
    send(8'h00, 0); check("t4_cpu_rst_c3", 32'(cpu_rst), 32'd1);
    send(8'h00, 0); check("t4_cpu_rst_c4", 32'(cpu_rst), 32'd0);
    check("t4_load_done", 32'(load_done), 32'd1);

    // Resync after DONE: junk ignored, MAGIC re-asserts cpu_rst next cycle.
    send(8'h55, 0);
    check("t5_junk_cpu_rst",   32'(cpu_rst),   32'd0);
    check("t5_junk_load_done", 32'(load_done), 32'd1);
    send(8'hA5, 0);
    check("t5_magic_cpu_rst",   32'(cpu_rst),   32'd1);
    check("t5_magic_load_done", 32'(load_done), 32'd0);
    base = wr_total;
    send(8'h01, 0); send(8'h00, 0);
    send(8'hEF, 0); send(8'hBE, 0); send(8'hAD, 0); send(8'hDE, 0);
    send(8'hC8, 0);
    idle(2);
    check("t5_load_done", 32'(load_done), 32'd1);
    check("t5_imem0",     mem[0], 32'hDEADBEEF);
    check("t5_nwrites",   32'(wr_total - base), 32'd1);

    // Full capacity: 32 words, word i = i; sum 496 -> 0xF0, CHK 0x10.
    base = wr_total;
    send(8'hA5, 0); send(8'h20, 0); send(8'h00, 0);
    for (int w = 0; w < 32; w++) begin
      send(8'(w), 0); send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
    end
    send(8'h10, 0);
    idle(2);
    check("full_load_done", 32'(load_done), 32'd1);
    check("full_nwrites",   32'(wr_total - base), 32'd32);
    check("full_imem0",     mem[0],  32'd0);
    check("full_imem17",    mem[17], 32'd17);
    check("full_imem31",    mem[31], 32'd31);
    check("full_waddr_max", 32'(imem_waddr), 32'd31);

    // Reset after the 5th data byte, then a clean reload.
    send(8'hA5, 1); send(8'h02, 2); send(8'h00, 0);
    send(8'h13, 3); send(8'h00, 1); send(8'h00, 0); send(8'h00, 2); send(8'h73, 1);
    rst = 1'b1;
    idle(2);
    check("t6_rst_cpu_rst",   32'(cpu_rst),    32'd1);
    check("t6_rst_load_done", 32'(load_done),  32'd0);
    check("t6_rst_load_err",  32'(load_err),   32'd0);
    check("t6_rst_waddr",     32'(imem_waddr), 32'd0);
    check("t6_rst_wdata",     imem_wdata,      32'd0);
    check("t6_rst_wen",       32'(imem_wen),   32'd0);
    check("t6_rst_s_ready",   32'(s_ready),    32'd0);
    rst = 1'b0;
    idle(1);
    base = wr_total;
    for (int k = 0; k < vecs[0].len; k++) send(vecs[0].b[k], int'($urandom_range(0, 3)));
    idle(2);
    check("t6_load_done", 32'(load_done), 32'd1);
    check("t6_cpu_rst",   32'(cpu_rst),   32'd0);
    check("t6_imem0",     mem[0], 32'h00000013);
    check("t6_imem1",     mem[1], 32'h00100073);
    check("t6_nwrites",   32'(wr_total - base), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
